// File: rtl/uart_pkg.sv
// Shared UART constants, phase type and divisor calculation used by the baud generator and RX/TX engines.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 16;
  localparam int FRAC_W     = 4;
  localparam int PHASE_W    = $clog2(OVERSAMPLE);

  typedef logic [PHASE_W-1:0] phase_t;

  typedef struct packed {
    logic [31:0] int_part;
    logic [31:0] frac_part;
  } div_cfg_t;

  // Rounds clk_hz/(baud*os) to the nearest 2^-frac_w; frac_w=0 gives a plain rounded integer divisor.
  function automatic div_cfg_t calc_div(input longint clk_hz, input longint baud,
                                        input longint os, input int frac_w);
    longint denom;
    longint scaled;
    div_cfg_t r;
    denom       = baud * os;
    scaled      = (((clk_hz << (frac_w + 1)) / denom) + 64'sd1) >>> 1;
    r.int_part  = 32'(scaled >>> frac_w);
    r.frac_part = 32'(scaled & ((64'sd1 <<< frac_w) - 64'sd1));
    return r;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-rate clock-enable generator: oversample, bit and mid-bit single-cycle enables on sysclk.
// Define BAUD_TICK_FRAC_EN to add the fractional-divisor accumulator.
module baud_tick_gen #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int DIV_W      = uart_pkg::DIV_W,
  parameter int FRAC_W     = uart_pkg::FRAC_W
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          sync_clr,
  input  logic                          div_load,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  output logic                          tick_os,
  output logic                          tick_bit,
  output logic                          tick_mid,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);
  import uart_pkg::*;

  localparam int PH_W = $clog2(OVERSAMPLE);

`ifdef BAUD_TICK_FRAC_EN
  localparam div_cfg_t DEF_CFG =
    calc_div(longint'(CLK_HZ), longint'(BAUD), longint'(OVERSAMPLE), FRAC_W);
`else
  localparam div_cfg_t DEF_CFG =
    calc_div(longint'(CLK_HZ), longint'(BAUD), longint'(OVERSAMPLE), 0);
`endif
  localparam logic [DIV_W-1:0] DEF_DIV = DEF_CFG.int_part[DIV_W-1:0];

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] div_act_reg;
  logic [DIV_W-1:0] shadow_int_reg;
  logic [PH_W-1:0]  phase_reg;
  logic             tick_os_reg;
  logic             tick_bit_reg;
  logic             tick_mid_reg;

  logic [DIV_W-1:0] load_int;
  logic [DIV_W-1:0] eff_int;
  logic             carry;

  // A load arriving on the reload edge itself is used for that reload.
  always_comb begin
    load_int = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
    eff_int  = div_load ? load_int : shadow_int_reg;
  end

`ifdef BAUD_TICK_FRAC_EN
  localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_CFG.frac_part[FRAC_W-1:0];

  logic [FRAC_W-1:0] acc_reg;
  logic [FRAC_W-1:0] frac_act_reg;
  logic [FRAC_W-1:0] shadow_frac_reg;
  logic [FRAC_W-1:0] eff_frac;
  logic [FRAC_W:0]   acc_sum;

  assign eff_frac = div_load ? div_frac : shadow_frac_reg;
  assign acc_sum  = {1'b0, acc_reg} + {1'b0, frac_act_reg};
  assign carry    = acc_sum[FRAC_W];

  always_ff @(posedge sysclk) begin
    if (reset) begin
      acc_reg         <= '0;
      frac_act_reg    <= DEF_FRAC;
      shadow_frac_reg <= DEF_FRAC;
    end else begin
      if (div_load) shadow_frac_reg <= div_frac;
      if (sync_clr) begin
        acc_reg <= '0;
        if (div_load) frac_act_reg <= div_frac;
      end else if (!en) begin
        if (div_load) frac_act_reg <= div_frac;
      end else if (cnt_reg == '0) begin
        acc_reg      <= acc_sum[FRAC_W-1:0];
        frac_act_reg <= eff_frac;
      end
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign carry       = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_reg        <= DEF_DIV - DIV_W'(1);
      div_act_reg    <= DEF_DIV;
      shadow_int_reg <= DEF_DIV;
      phase_reg      <= '0;
      tick_os_reg    <= 1'b0;
      tick_bit_reg   <= 1'b0;
      tick_mid_reg   <= 1'b0;
    end else begin
      tick_os_reg  <= 1'b0;
      tick_bit_reg <= 1'b0;
      tick_mid_reg <= 1'b0;
      if (div_load) shadow_int_reg <= load_int;

      if (sync_clr) begin
        phase_reg <= '0;
        if (div_load) begin
          div_act_reg <= load_int;
          cnt_reg     <= load_int - DIV_W'(1);
        end else begin
          cnt_reg     <= div_act_reg - DIV_W'(1);
        end
      end else if (!en) begin
        // Paused: a new divisor takes effect immediately since no period is in flight.
        if (div_load) begin
          div_act_reg <= load_int;
          cnt_reg     <= load_int - DIV_W'(1);
        end
      end else if (cnt_reg == '0) begin
        div_act_reg  <= eff_int;
        cnt_reg      <= eff_int - DIV_W'(1) + DIV_W'(carry);
        phase_reg    <= phase_reg + PH_W'(1);
        tick_os_reg  <= 1'b1;
        tick_bit_reg <= (phase_reg == PH_W'(OVERSAMPLE - 1));
        tick_mid_reg <= (phase_reg == PH_W'(OVERSAMPLE / 2 - 1));
      end else begin
        cnt_reg <= cnt_reg - DIV_W'(1);
      end
    end
  end

  assign tick_os  = tick_os_reg;
  assign tick_bit = tick_bit_reg;
  assign tick_mid = tick_mid_reg;
  assign os_phase = phase_reg;

endmodule
